platform_mover: RTL and testbench

PLATFORM_MOVER -- requirements
Module: platform_mover

---
 rtl/platform_pkg.sv | 15 +
 rtl/width_saturator.sv | 30 +++
 rtl/platform_mover.sv | 133 +++++++++++++
 tb/tb_platform_mover.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/platform_pkg.sv
// Shared constants and FSM state type for the platform mover.
package platform_pkg;

   localparam int FIXED_POINT_MULTIPLIER = 64;
   localparam int SCREEN_WIDTH = 640;
   localparam int SCREEN_HEIGHT = 480;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_UPDATE = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

endpackage

// File: rtl/width_saturator.sv
// Next platform width from grow/shrink requests, saturating at the limits.
module width_saturator
   import platform_pkg::*;
#(
   parameter int WIDTH_STEP = 8,
   parameter int MIN_WIDTH = 16,
   parameter int MAX_WIDTH = 160
) (
   input  logic signed [10:0] width_cur,
   input  logic               grow,
   input  logic               shrink,
   output logic signed [10:0] width_next
);

   logic signed [11:0] grown;
   logic signed [11:0] shrunk;

   // One extra bit keeps the sum/difference from wrapping before the limit compare.
   always_comb begin
      grown = $signed({width_cur[10], width_cur}) + $signed(12'(WIDTH_STEP));
      shrunk = $signed({width_cur[10], width_cur}) - $signed(12'(WIDTH_STEP));
      width_next = width_cur;
      if (grow && !shrink) begin
         width_next = (grown > $signed(12'(MAX_WIDTH))) ? 11'(MAX_WIDTH) : grown[10:0];
      end else if (shrink && !grow) begin
         width_next = (shrunk < $signed(12'(MIN_WIDTH))) ? 11'(MIN_WIDTH) : shrunk[10:0];
      end
   end

endmodule

// File: rtl/platform_mover.sv
// Horizontally bouncing platform: moves once per frame, freezes after a hit,
// and grows/shrinks on request.
module platform_mover
   import platform_pkg::*;
#(
   parameter int INITIAL_X = 280,
   parameter int INITIAL_Y = 185,
   parameter int INITIAL_WIDTH = 64,
   parameter int X_SPEED = 120,
   parameter int WIDTH_STEP = 8,
   parameter int MIN_WIDTH = 16,
   parameter int MAX_WIDTH = 160,
   parameter int HOLD_FRAMES = 4
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               enable,
   input  logic               collision,
   input  logic               grow_req,
   input  logic               shrink_req,
   output logic signed [10:0] topLeftX_w,
   output logic signed [10:0] topLeftY_w,
   output logic signed [10:0] widthX,
   output logic               frame_done
);

   localparam logic signed [31:0] SPEED_FP = 32'(X_SPEED);
   localparam logic signed [31:0] RIGHT_LIMIT_FP = 32'(SCREEN_WIDTH * FIXED_POINT_MULTIPLIER);
   localparam logic signed [31:0] RESET_X_FP = 32'(INITIAL_X * FIXED_POINT_MULTIPLIER);

   state_t             state;
   logic               dir;
   logic               coll_latch;
   logic               grow_latch;
   logic               shrink_latch;
   logic [7:0]         hold_cnt;
   logic signed [31:0] x_fp;
   logic signed [31:0] x_step;
   logic signed [31:0] x_next;
   logic signed [31:0] width_fp;
   logic               dir_next;
   logic signed [10:0] width_new;

   width_saturator #(
      .WIDTH_STEP(WIDTH_STEP),
      .MIN_WIDTH (MIN_WIDTH),
      .MAX_WIDTH (MAX_WIDTH)
   ) u_width_saturator (
      .width_cur (widthX),
      .grow      (grow_latch),
      .shrink    (shrink_latch),
      .width_next(width_new)
   );

   assign topLeftY_w = 11'(INITIAL_Y);

   // Edge checks use the width that will be in force after this update.
   always_comb begin
      width_fp = 32'(width_new) * FIXED_POINT_MULTIPLIER;
      x_step = dir ? (x_fp - SPEED_FP) : (x_fp + SPEED_FP);
      x_next = x_step;
      dir_next = dir;
      if (!dir && ((x_step + width_fp) >= RIGHT_LIMIT_FP)) begin
         x_next = RIGHT_LIMIT_FP - width_fp;
         dir_next = 1'b1;
      end else if (dir && (x_step <= 0)) begin
         x_next = '0;
         dir_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (resetN) begin
         state <= S_IDLE;
         dir <= 1'b0;
         x_fp <= RESET_X_FP;
         widthX <= 11'(INITIAL_WIDTH);
         topLeftX_w <= 11'(INITIAL_X);
         coll_latch <= 1'b0;
         grow_latch <= 1'b0;
         shrink_latch <= 1'b0;
         hold_cnt <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (collision) coll_latch <= 1'b1;
         if (grow_req) grow_latch <= 1'b1;
         if (shrink_req) shrink_latch <= 1'b1;
         case (state)
            S_IDLE: begin
               if (enable) state <= S_RUN;
            end
            S_RUN: begin
               if (!enable) state <= S_IDLE;
               else if (startOfFrame) state <= S_UPDATE;
            end
            S_UPDATE: begin
               // Latches are consumed here; a request arriving this very cycle survives.
               coll_latch <= collision;
               grow_latch <= grow_req;
               shrink_latch <= shrink_req;
               widthX <= width_new;
               frame_done <= 1'b1;
               if (coll_latch) begin
                  dir <= ~dir;
                  hold_cnt <= 8'(HOLD_FRAMES);
                  state <= S_HOLD;
               end else begin
                  x_fp <= x_next;
                  dir <= dir_next;
                  topLeftX_w <= 11'(x_next / FIXED_POINT_MULTIPLIER);
                  state <= S_RUN;
               end
            end
            S_HOLD: begin
               if (!enable) begin
                  state <= S_IDLE;
               end else if (startOfFrame) begin
                  if (hold_cnt <= 8'd1) begin
                     hold_cnt <= '0;
                     state <= S_RUN;
                  end else begin
                     hold_cnt <= hold_cnt - 8'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_platform_mover.sv
// Scoreboard bench for platform_mover: a frame-level reference model predicts
// each frame_done result, and a monitor compares them as they appear.
module tb_platform_mover;
   import platform_pkg::*;

   logic clk = 1'b0;
   logic resetN = 1'b1;
   logic startOfFrame = 1'b0;
   logic enable = 1'b0;
   logic collision = 1'b0;
   logic grow_req = 1'b0;
   logic shrink_req = 1'b0;
   logic signed [10:0] topLeftX_w;
   logic signed [10:0] topLeftY_w;
   logic signed [10:0] widthX;
   logic frame_done;

   always #5 clk = ~clk;

   platform_mover dut (
      .clk         (clk),
      .resetN      (resetN),
      .startOfFrame(startOfFrame),
      .enable      (enable),
      .collision   (collision),
      .grow_req    (grow_req),
      .shrink_req  (shrink_req),
      .topLeftX_w  (topLeftX_w),
      .topLeftY_w  (topLeftY_w),
      .widthX      (widthX),
      .frame_done  (frame_done)
   );

   typedef struct {
      int x;
      int w;
      int edgeIdx;
   } exp_t;

   typedef enum {M_STOPPED, M_MOVING, M_FROZEN} mmode_t;

   exp_t expQ[$];
   exp_t cur;
   int errors = 0;
   int checks = 0;
   int edgeCnt = 0;
   int doneCnt = 0;
   int doneBefore;

   int mPos;
   int mWidth;
   int mFrozen;
   bit mDir;
   bit mColl;
   bit mGrow;
   bit mShrink;
   bit mPending;
   mmode_t mMode;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic modelReset();
      mPos = 280 * 64;
      mWidth = 64;
      mDir = 1'b0;
      mColl = 1'b0;
      mGrow = 1'b0;
      mShrink = 1'b0;
      mPending = 1'b0;
      mFrozen = 0;
      mMode = M_STOPPED;
      expQ.delete();
   endtask

   // One frame of platform behaviour, expressed in pixels and fixed-point units.
   task automatic modelFrame(input int edgeIdx);
      int p;
      exp_t e;
      if (mGrow && !mShrink) mWidth = (mWidth + 8 > 160) ? 160 : mWidth + 8;
      else if (mShrink && !mGrow) mWidth = (mWidth - 8 < 16) ? 16 : mWidth - 8;
      if (mColl) begin
         mDir = !mDir;
         mFrozen = 4;
         mMode = M_FROZEN;
      end else begin
         p = mDir ? mPos - 120 : mPos + 120;
         if (!mDir && (real'(p) / 64.0 + real'(mWidth) >= 640.0)) begin
            p = (640 - mWidth) * 64;
            mDir = 1'b1;
         end else if (mDir && p <= 0) begin
            p = 0;
            mDir = 1'b0;
         end
         mPos = p;
         mMode = M_MOVING;
      end
      e.x = mPos / 64;
      e.w = mWidth;
      e.edgeIdx = edgeIdx;
      expQ.push_back(e);
   endtask

   task automatic modelEdge(input bit sof, input bit en, input bit col, input bit gr, input bit sh,
                            input int edgeIdx);
      if (mPending) begin
         modelFrame(edgeIdx);
         mPending = 1'b0;
         mColl = col;
         mGrow = gr;
         mShrink = sh;
      end else begin
         mColl = mColl | col;
         mGrow = mGrow | gr;
         mShrink = mShrink | sh;
         if (!en) mMode = M_STOPPED;
         else if (mMode == M_STOPPED) mMode = M_MOVING;
         else if (sof && mMode == M_MOVING) mPending = 1'b1;
         else if (sof && mMode == M_FROZEN) begin
            mFrozen--;
            if (mFrozen == 0) mMode = M_MOVING;
         end
      end
   endtask

   task automatic applyStimulus(input bit sof, input bit en, input bit col, input bit gr, input bit sh);
      @(negedge clk);
      resetN = 1'b0;
      startOfFrame = sof;
      enable = en;
      collision = col;
      grow_req = gr;
      shrink_req = sh;
      modelEdge(sof, en, col, gr, sh, edgeCnt + 1);
   endtask

   task automatic runFrame(input bit col, input bit gr, input bit sh, input int gap);
      applyStimulus(1'b0, 1'b1, col, gr, sh);
      repeat (gap) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic doReset(input string tag);
      @(negedge clk);
      resetN = 1'b1;
      startOfFrame = 1'b0;
      enable = 1'b0;
      collision = 1'b0;
      grow_req = 1'b0;
      shrink_req = 1'b0;
      modelReset();
      @(negedge clk);
      checkOutput({tag, "_x"}, topLeftX_w, 280);
      checkOutput({tag, "_y"}, topLeftY_w, 185);
      checkOutput({tag, "_width"}, widthX, 64);
      checkOutput({tag, "_frame_done"}, frame_done, 0);
      checkOutput({tag, "_state"}, int'(dut.state), int'(S_IDLE));
      resetN = 1'b0;
      modelEdge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, edgeCnt + 1);
   endtask

   // Monitor: pops the oldest expected frame whenever frame_done appears.
   always @(posedge clk) begin
      edgeCnt++;
      #1;
      if (frame_done) begin
         doneCnt++;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_frame_done: got pulse at edge %0d, expected none", edgeCnt);
         end else begin
            cur = expQ.pop_front();
            checkOutput("frame_edge", edgeCnt, cur.edgeIdx);
            checkOutput("frame_x", topLeftX_w, cur.x);
            checkOutput("frame_width", widthX, cur.w);
            checkOutput("frame_y", topLeftY_w, 185);
         end
      end else if (expQ.size() > 0 && expQ[0].edgeIdx <= edgeCnt) begin
         cur = expQ.pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL missing_frame_done: got none at edge %0d, expected pulse (x=%0d w=%0d)",
                  edgeCnt, cur.x, cur.w);
      end
   end

   initial begin
      modelReset();
      doReset("reset");

      // First frame after enabling.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      runFrame(1'b0, 1'b0, 1'b0, 1);
      checkOutput("first_frame_x", topLeftX_w, 281);

      // Travel right until the edge bounce.
      for (int i = 0; i < 400 && !mDir; i++) runFrame(1'b0, 1'b0, 1'b0, 0);
      checkOutput("right_edge_x", topLeftX_w, 576);
      checkOutput("right_edge_dir", dut.dir, 1);

      // Collision: frozen for exactly four frames, then moving again.
      runFrame(1'b1, 1'b0, 1'b0, 2);
      checkOutput("coll_x", topLeftX_w, 576);
      checkOutput("coll_dir", dut.dir, 0);
      doneBefore = doneCnt;
      repeat (4) runFrame(1'b0, 1'b0, 1'b0, 1);
      checkOutput("hold_no_frames", doneCnt - doneBefore, 0);
      repeat (2) runFrame(1'b0, 1'b0, 1'b0, 1);
      checkOutput("resume_frames", doneCnt - doneBefore, 2);

      // Collision together with a right-edge event and a grow request.
      runFrame(1'b1, 1'b0, 1'b0, 1);
      repeat (4) runFrame(1'b0, 1'b0, 1'b0, 0);
      runFrame(1'b1, 1'b1, 1'b0, 1);
      checkOutput("coll_edge_state", int'(dut.state), int'(S_HOLD));
      checkOutput("coll_edge_x", topLeftX_w, mPos / 64);
      checkOutput("coll_edge_width", widthX, 72);
      repeat (4) runFrame(1'b0, 1'b0, 1'b0, 0);

      // Shrink down to the floor, then grow+shrink together.
      runFrame(1'b0, 1'b0, 1'b1, 0);
      for (int i = 0; i < 20; i++) runFrame(1'b0, 1'b0, 1'b1, i % 3);
      checkOutput("shrink_floor", widthX, 16);
      runFrame(1'b0, 1'b1, 1'b1, 1);
      checkOutput("grow_shrink_same", widthX, 16);

      // Travel left until the edge bounce.
      for (int i = 0; i < 400 && mDir; i++) runFrame(1'b0, 1'b0, 1'b0, 0);
      checkOutput("left_edge_x", topLeftX_w, 0);
      checkOutput("left_edge_dir", dut.dir, 0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(5) == 0, $urandom_range(40) != 0, $urandom_range(24) == 0,
                       $urandom_range(7) == 0, $urandom_range(7) == 0);
      end

      // Reset while frozen.
      doReset("mid_reset");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      runFrame(1'b1, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("hold_before_reset", int'(dut.state), int'(S_HOLD));
      doReset("hold_reset");

      repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("queue_empty", expQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
